// File: rtl/door_motor_driver.sv
// rtl/door_motor_driver.sv - gated PWM H-bridge drive with dead time, soft-start ramp and latched over-current fault
module door_motor_driver #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_STEP   = 32,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                UP_M,
  input  logic                DOWN_M,
  input  logic                OVER_CUR,
  input  logic                CLR_FAULT,
  output logic                HS_UP,
  output logic                HS_DN,
  output logic [PWM_BITS-1:0] DUTY,
  output logic                FAULT,
  output logic                BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_DEAD, S_RAMP, S_RUN, S_FAULT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  localparam logic [7:0]          DEAD_LOAD = 8'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(RAMP_STEP);

  state_t              state, state_n;
  dir_t                dir, dir_n, cmd;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [7:0]          dead_cnt, dead_n;
  logic                fault_q, fault_n;
  logic                hs_up_q, hs_dn_q, busy_q;
  logic [PWM_BITS:0]   ramp_sum;
  logic                period_end;
  logic                driving;

  always_comb begin
    cmd = DIR_NONE;
    if (UP_M && !DOWN_M)      cmd = DIR_UP;
    else if (DOWN_M && !UP_M) cmd = DIR_DN;
  end

  assign period_end = &pwm_cnt;
  assign ramp_sum   = {1'b0, duty} + STEP_W;
  assign driving    = (state == S_RAMP) || (state == S_RUN);

  always_comb begin
    state_n = state;
    dir_n   = dir;
    duty_n  = duty;
    dead_n  = dead_cnt;
    fault_n = fault_q;
    if (OVER_CUR) begin
      state_n = S_FAULT;
      duty_n  = '0;
      dir_n   = DIR_NONE;
      fault_n = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          duty_n = '0;
          if (cmd != DIR_NONE) begin
            dir_n   = cmd;
            dead_n  = DEAD_LOAD;
            state_n = S_DEAD;
          end
        end
        S_DEAD: begin
          duty_n = '0;
          if (cmd != dir) begin
            dir_n  = cmd;
            dead_n = DEAD_LOAD;
          end else if (dead_cnt == 8'd0) begin
            state_n = (dir == DIR_NONE) ? S_IDLE : S_RAMP;
          end else begin
            dead_n = dead_cnt - 8'd1;
          end
        end
        S_RAMP, S_RUN: begin
          if (cmd != dir) begin
            // Stop/reversal is immediate; the dead time protects the bridge.
            duty_n  = '0;
            dir_n   = cmd;
            dead_n  = DEAD_LOAD;
            state_n = S_DEAD;
          end else if (state == S_RUN) begin
            duty_n = DUTY_MAX;
          end else if (period_end) begin
            if (ramp_sum >= {1'b0, DUTY_MAX}) begin
              duty_n  = DUTY_MAX;
              state_n = S_RUN;
            end else begin
              duty_n = ramp_sum[PWM_BITS-1:0];
            end
          end
        end
        S_FAULT: begin
          duty_n = '0;
          dir_n  = DIR_NONE;
          if (CLR_FAULT && cmd == DIR_NONE) begin
            fault_n = 1'b0;
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
          duty_n  = '0;
          dir_n   = DIR_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      dir      <= DIR_NONE;
      duty     <= '0;
      pwm_cnt  <= '0;
      dead_cnt <= 8'd0;
      fault_q  <= 1'b0;
      hs_up_q  <= 1'b0;
      hs_dn_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      duty     <= duty_n;
      pwm_cnt  <= pwm_cnt + 1'b1;
      dead_cnt <= dead_n;
      fault_q  <= fault_n;
      hs_up_q  <= driving && (dir == DIR_UP) && (pwm_cnt < duty);
      hs_dn_q  <= driving && (dir == DIR_DN) && (pwm_cnt < duty);
      busy_q   <= (state_n != S_IDLE);
    end
  end

  assign HS_UP = hs_up_q;
  assign HS_DN = hs_dn_q;
  assign DUTY  = duty;
  assign FAULT = fault_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_door_motor_driver.sv
// tb/tb_door_motor_driver.sv - directed self-checking bench for door_motor_driver
module tb_door_motor_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UP_M = 1'b0;
  logic       DOWN_M = 1'b0;
  logic       OVER_CUR = 1'b0;
  logic       CLR_FAULT = 1'b0;
  logic       HS_UP, HS_DN, FAULT, BUSY;
  logic [7:0] DUTY;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic seen_up, seen_dn, seen_both;

  door_motor_driver #(.PWM_BITS(8), .RAMP_STEP(32), .DEAD_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .UP_M(UP_M), .DOWN_M(DOWN_M), .OVER_CUR(OVER_CUR),
    .CLR_FAULT(CLR_FAULT), .HS_UP(HS_UP), .HS_DN(HS_DN), .DUTY(DUTY),
    .FAULT(FAULT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (HS_UP) seen_up = 1'b1;
    if (HS_DN) seen_dn = 1'b1;
    if (HS_UP && HS_DN) seen_both = 1'b1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic clear_seen();
    seen_up = 1'b0;
    seen_dn = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    seen_both = 1'b0;
    clear_seen();
    tick();
    tick();
    check("rst_hs_up", HS_UP, 0);
    check("rst_hs_dn", HS_DN, 0);
    check("rst_duty", DUTY, 0);
    check("rst_fault", FAULT, 0);
    check("rst_busy", BUSY, 0);

    // Scenario 1: open from reset; edge numbering restarts at the first non-reset edge
    cyc = 0;
    RST = 1'b0;
    UP_M = 1'b1;
    clear_seen();
    run_to(1);
    check("up_busy", BUSY, 1);
    check("up_duty_dead", DUTY, 0);
    run_to(256);
    check("up_no_drive_pre_ramp", seen_up, 0);
    check("up_duty_p1", DUTY, 32);
    run_to(257);
    check("up_hs_on_cnt0", HS_UP, 1);
    run_to(288);
    check("up_hs_on_cnt31", HS_UP, 1);
    run_to(289);
    check("up_hs_off_cnt32", HS_UP, 0);
    for (int p = 2; p <= 7; p++) begin
      run_to(256 * p - 1);
      check("up_duty_hold", DUTY, 32 * (p - 1));
      run_to(256 * p);
      check("up_duty_step", DUTY, 32 * p);
    end
    run_to(2048);
    check("up_duty_sat", DUTY, 255);
    run_to(2303);
    check("run_hs_on_cnt254", HS_UP, 1);
    run_to(2304);
    check("run_hs_off_cnt255", HS_UP, 0);
    check("up_no_dn", seen_dn, 0);

    // Scenario 2: reversal to down
    UP_M = 1'b0;
    DOWN_M = 1'b1;
    clear_seen();
    run_to(2305);
    check("rev_duty0", DUTY, 0);
    check("rev_busy", BUSY, 1);
    run_to(2306);
    check("rev_hs_up_off", HS_UP, 0);
    run_to(2559);
    check("rev_duty_pre", DUTY, 0);
    check("rev_dn_quiet", seen_dn, 0);
    run_to(2560);
    check("rev_duty_p1", DUTY, 32);
    run_to(2561);
    check("rev_hs_dn_on", HS_DN, 1);
    run_to(4351);
    check("rev_duty_224", DUTY, 224);
    run_to(4352);
    check("rev_duty_255", DUTY, 255);

    // Scenario 3: both commands high stops the motor
    UP_M = 1'b1;
    clear_seen();
    run_to(4354);
    check("both_hs_dn_off", HS_DN, 0);
    check("both_duty0", DUTY, 0);
    run_to(4356);
    check("both_busy_dead", BUSY, 1);
    run_to(4357);
    check("both_busy_idle", BUSY, 0);
    check("both_hs_up", HS_UP, 0);
    check("both_hs_dn", HS_DN, 0);

    // Scenario 4: command toggles during dead time
    DOWN_M = 1'b0;
    clear_seen();
    run_to(4359);
    UP_M = 1'b0;
    DOWN_M = 1'b1;
    run_to(4361);
    UP_M = 1'b1;
    DOWN_M = 1'b0;
    run_to(4607);
    check("tog_duty_pre", DUTY, 0);
    check("tog_busy", BUSY, 1);
    check("tog_no_up", seen_up, 0);
    check("tog_no_dn", seen_dn, 0);
    run_to(4608);
    check("tog_duty_p1", DUTY, 32);
    run_to(4609);
    check("tog_hs_up", HS_UP, 1);
    check("tog_hs_dn", HS_DN, 0);

    // Scenario 5: over-current mid-ramp at duty 96
    run_to(5120);
    check("oc_duty96", DUTY, 96);
    OVER_CUR = 1'b1;
    run_to(5121);
    OVER_CUR = 1'b0;
    check("oc_fault", FAULT, 1);
    check("oc_duty0", DUTY, 0);
    run_to(5122);
    check("oc_hs_up_off", HS_UP, 0);
    CLR_FAULT = 1'b1;
    run_to(5124);
    check("oc_clr_with_cmd", FAULT, 1);
    check("oc_busy", BUSY, 1);
    UP_M = 1'b0;
    run_to(5125);
    check("oc_cleared", FAULT, 0);
    check("oc_idle_busy", BUSY, 0);

    // Scenario 6: over-current held against clear, then reset
    OVER_CUR = 1'b1;
    run_to(5126);
    check("ocheld_fault", FAULT, 1);
    run_to(5130);
    check("ocheld_fault_stays", FAULT, 1);
    RST = 1'b1;
    run_to(5131);
    check("rst2_fault", FAULT, 0);
    check("rst2_busy", BUSY, 0);
    check("rst2_duty", DUTY, 0);
    check("rst2_hs", {HS_UP, HS_DN}, 0);
    check("never_both", seen_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/door_motor_driver.md
Name: door_motor_driver

Overview:
Downstream stage of the door controller FSM. Converts the level motor commands UP_M / DOWN_M into two gated PWM drive signals for the H-bridge. Enforces a dead time on every start, stop and reversal, soft-starts the motor with a duty ramp, and latches an over-current fault that kills drive until it is explicitly cleared.

Parameters:
PWM_BITS, 8, width of the PWM counter and duty register; period = 2^PWM_BITS cycles
RAMP_STEP, 32, duty increment applied once per PWM period while ramping
DEAD_CYCLES, 4, cycles both drives are held off before any drive starts (range 1..255)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
UP_M  input  1  open-door command level from the door controller
DOWN_M  input  1  close-door command level from the door controller
OVER_CUR  input  1  over-current flag from the bridge sense comparator, already synchronised
CLR_FAULT  input  1  fault clear request, level
HS_UP  output  1  registered PWM drive, up leg
HS_DN  output  1  registered PWM drive, down leg
DUTY  output  PWM_BITS  current duty register value
FAULT  output  1  latched over-current indication
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset: state IDLE, dir NONE, duty 0, pwm_cnt 0, dead_cnt 0, HS_UP=HS_DN=0, FAULT=0, BUSY=0.
- Command decode: UP_M & !DOWN_M gives UP. DOWN_M & !UP_M gives DN. Both low or both high gives NONE.
- pwm_cnt is free-running in every state, 0 to 2^PWM_BITS-1, then wraps to 0. A period end is the cycle with pwm_cnt = all-ones.
- Drive outputs are registered, with one cycle of latency. At edge t+1:
  - HS_UP = (state in RAMP/RUN) & dir==UP & (pwm_cnt < duty), all sampled at t.
  - HS_DN is the same with dir==DN.
  - HS_UP and HS_DN are never high together.
- Priority: RST, then OVER_CUR, then CLR_FAULT, then command.
- States:
  - IDLE: duty 0. If cmd != NONE: dir <= cmd, dead_cnt <= DEAD_CYCLES-1, go DEAD.
  - DEAD: both drives 0, duty 0.
    - If cmd != dir: dir <= cmd, reload dead_cnt, stay in DEAD.
    - Otherwise, when dead_cnt = 0: go IDLE if dir==NONE, else go RAMP with duty 0.
    - Otherwise decrement dead_cnt.
    - A stable command therefore gives exactly DEAD_CYCLES cycles in DEAD.
  - RAMP: at each period end, duty <= min(duty+RAMP_STEP, 2^PWM_BITS-1). The sum is computed PWM_BITS+1 wide and saturates, with no wrap. On the edge where duty becomes all-ones, go RUN.
  - RUN: duty held at all-ones. Drive is low only in the cnt = all-ones cycle.
  - Leaving RAMP/RUN: if cmd != dir (stop, reversal or both-high), on that edge duty <= 0, dir <= cmd, dead_cnt <= DEAD_CYCLES-1, go DEAD. Drives are 0 from the following edge. Stopping is immediate, with no ramp-down.
  - FAULT: entered from any state on the edge after OVER_CUR=1. On that edge duty <= 0, dir <= NONE and FAULT <= 1; drives are 0 from the next edge. Exit to IDLE only when CLR_FAULT=1, OVER_CUR=0 and cmd=NONE in the same cycle; FAULT <= 0 on that edge. In every other cycle, stay in FAULT.
- OVER_CUR asserted in the same cycle as CLR_FAULT: stay in FAULT.
- Reset mid-ramp or in FAULT: immediate return to the reset values on the next edge.
- DUTY output mirrors the duty register. BUSY is registered with the state.

Test Plan:
- Reset, then UP_M=1: BUSY=1 next cycle. HS_UP=0 for 4 DEAD cycles plus 1 latency cycle. Duty steps 32, 64, … 224, then 255 at successive period ends (8 periods = 2048 cycles), then RUN. HS_DN stays 0 throughout.
- In RUN up, switch to DOWN_M=1, UP_M=0: HS_UP=0 within 2 edges, DUTY=0. HS_DN stays 0 for 4 cycles, then ramps from 0 exactly as in the first scenario.
- UP_M=DOWN_M=1 while in RUN: drive stops and the block goes DEAD→IDLE after 4 cycles, with BUSY=0 and both drives 0.
- Command toggled UP→DN→UP on every 2nd cycle during DEAD: dead_cnt reloads and no drive pulse ever occurs. After the command holds for 4 cycles, RAMP starts in the held direction.
- OVER_CUR pulse of 1 cycle mid-ramp at duty 96: FAULT=1, DUTY=0, drives 0. CLR_FAULT with UP_M=1 is ignored. With CLR_FAULT=1 and cmd NONE, go IDLE with FAULT=0.
- OVER_CUR held high with CLR_FAULT=1: FAULT stays 1. RST=1 for 1 cycle: all outputs 0 on the next edge.
